fir_serial_mac: RTL and testbench

//  Parametrised time-multiplexed FIR filter: one shared multiply-accumulate (MAC) unit

---
 rtl/fir_serial_mac.sv | 170 +++++++++++++++++
 tb/tb_fir_serial_mac.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_serial_mac.sv
// fir_serial_mac -- time-multiplexed FIR filter built around one shared MAC.
//
// A sample is accepted in IDLE and pushed into the delay line. The filter then
// spends TAPS cycles in MAC, adding one product x[k]*c[k] per cycle. It then
// holds the scaled and narrowed result in OUT until downstream takes it.
//
// Ports
//   clk, reset        clock; asynchronous active-high reset
//   in_valid_i        input sample valid
//   in_ready_o        sample can be accepted (IDLE only)
//   in_data_i         signed input sample
//   out_valid_o       filtered result valid (OUT)
//   out_ready_i       downstream accepts result
//   out_data_o        signed result: (acc >>> OUT_SHIFT) narrowed to OUT_W bits
//   out_sat_o         result was clamped (saturating build only, else 0)
//   coef_we_i         coefficient write strobe, honoured in every state
//   coef_addr_i       coefficient index, 0 = newest-sample tap; >= TAPS ignored
//   coef_wdata_i      signed coefficient value
//
// Build option
//   FIR_OUT_SAT_EN    when defined, out-of-range results clamp to the OUT_W
//                     bounds and set out_sat_o; otherwise results wrap.
//
// State | meaning
//   IDLE  | waiting for a sample, in_ready_o high
//   MAC   | accumulating tap k_q, one tap per cycle
//   OUT   | result presented, waiting for out_ready_i
module fir_serial_mac #(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int TAPS      = 9,
  parameter int ACC_W     = DATA_W + COEF_W + $clog2(TAPS),
  parameter int OUT_SHIFT = 0,
  parameter int OUT_W     = 36
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic signed [DATA_W-1:0]   in_data_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic        [OUT_W-1:0]    out_data_o,
  output logic                       out_sat_o,
  input  logic                       coef_we_i,
  input  logic [$clog2(TAPS)-1:0]    coef_addr_i,
  input  logic signed [COEF_W-1:0]   coef_wdata_i
);

  localparam int AW = $clog2(TAPS);
  localparam logic [AW-1:0] K_LAST = AW'(TAPS - 1);
  localparam logic [AW:0]   TAPS_L = (AW + 1)'(TAPS);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  state_t                     state_q, state_d;
  logic signed [DATA_W-1:0]   x_q [TAPS];
  logic signed [DATA_W-1:0]   x_d [TAPS];
  logic signed [COEF_W-1:0]   c_q [TAPS];
  logic signed [COEF_W-1:0]   c_d [TAPS];
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic [AW-1:0]              k_q, k_d;
  logic [OUT_W-1:0]           out_data_q, out_data_d;
  logic                       out_sat_q, out_sat_d;

  logic signed [DATA_W+COEF_W-1:0] prod;
  logic signed [ACC_W-1:0]         acc_sum;
  logic signed [ACC_W-1:0]         r;
  logic [OUT_W-1:0]                narrow_data;
  logic                            narrow_sat;

  // Coefficient is read from the register, so a write landing on the same
  // edge as the read of that tap only affects later samples.
  assign prod    = x_q[k_q] * c_q[k_q];
  assign acc_sum = acc_q + ACC_W'(prod);
  assign r       = acc_sum >>> OUT_SHIFT;

`ifdef FIR_OUT_SAT_EN
  // r fits in OUT_W bits only if every bit from OUT_W-1 upward equals the sign.
  logic [ACC_W-OUT_W:0] r_hi;
  assign r_hi = r[ACC_W-1:OUT_W-1];

  always_comb begin
    narrow_data = r[OUT_W-1:0];
    narrow_sat  = 1'b0;
    if (!((&r_hi) || !(|r_hi))) begin
      narrow_sat  = 1'b1;
      narrow_data = r[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                               : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end
`else
  logic unused_r;
  assign unused_r    = ^r;
  assign narrow_data = r[OUT_W-1:0];
  assign narrow_sat  = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    c_d        = c_q;
    acc_d      = acc_q;
    k_d        = k_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;

    if (coef_we_i && ({1'b0, coef_addr_i} < TAPS_L)) begin
      c_d[coef_addr_i] = coef_wdata_i;
    end

    case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          x_d[0] = in_data_i;
          for (int i = 1; i < TAPS; i++) begin
            x_d[i] = x_q[i-1];
          end
          acc_d   = '0;
          k_d     = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_sum;
        k_d   = k_q + AW'(1);
        if (k_q == K_LAST) begin
          k_d        = '0;
          out_data_d = narrow_data;
          out_sat_d  = narrow_sat;
          state_d    = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      k_q        <= '0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        x_q[i] <= '0;
        c_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      k_q        <= k_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
      x_q        <= x_d;
      c_q        <= c_d;
    end
  end

  assign in_ready_o  = (state_q == S_IDLE);
  assign out_valid_o = (state_q == S_OUT);
  assign out_data_o  = out_data_q;
  assign out_sat_o   = out_sat_q;

endmodule

// File: tb/tb_fir_serial_mac.sv
// Testbench for fir_serial_mac. Two instances share all inputs: A uses the
// default 36-bit output, B narrows to 16 bits after a 4-bit shift. The driver
// models the filter as a dot product of the sample history with the
// coefficient set seen by each tap, and queues the expected result; a
// separate monitor drives out_ready and pops/compares on every handshake.
module tb_fir_serial_mac;
  localparam int TAPS = 9;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        out_ready = 1'b1;
  logic        coef_we = 1'b0;
  logic [3:0]  coef_addr = '0;
  logic [15:0] coef_wdata = '0;

  logic        in_ready_a, out_valid_a, out_sat_a;
  logic [35:0] out_data_a;
  logic        in_ready_b, out_valid_b, out_sat_b;
  logic [15:0] out_data_b;

  always #5 clk = ~clk;

  fir_serial_mac u_dut_a (
    .clk(clk), .reset(reset),
    .in_valid_i(in_valid), .in_ready_o(in_ready_a), .in_data_i(in_data),
    .out_valid_o(out_valid_a), .out_ready_i(out_ready),
    .out_data_o(out_data_a), .out_sat_o(out_sat_a),
    .coef_we_i(coef_we), .coef_addr_i(coef_addr), .coef_wdata_i(coef_wdata)
  );

  fir_serial_mac #(.OUT_SHIFT(4), .OUT_W(16)) u_dut_b (
    .clk(clk), .reset(reset),
    .in_valid_i(in_valid), .in_ready_o(in_ready_b), .in_data_i(in_data),
    .out_valid_o(out_valid_b), .out_ready_i(out_ready),
    .out_data_o(out_data_b), .out_sat_o(out_sat_b),
    .coef_we_i(coef_we), .coef_addr_i(coef_addr), .coef_wdata_i(coef_wdata)
  );

  typedef struct {
    logic [35:0] a;
    logic [15:0] b;
    logic        sb;
  } exp_t;

  exp_t   q[$];
  longint xm [TAPS];
  longint cm [TAPS];
  int     n_vec = 0;
  int     n_err = 0;
  int     rdy_pct = 100;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint sx16(input logic [15:0] v);
    return longint'($signed(v));
  endfunction

  function automatic exp_t mk_exp(input longint s);
    exp_t   e;
    longint r;
    r    = s >>> 4;
    e.a  = s[35:0];
`ifdef FIR_OUT_SAT_EN
    if (r > 32767) begin
      e.b = 16'h7FFF; e.sb = 1'b1;
    end else if (r < -32768) begin
      e.b = 16'h8000; e.sb = 1'b1;
    end else begin
      e.b = r[15:0]; e.sb = 1'b0;
    end
`else
    e.b  = r[15:0];
    e.sb = 1'b0;
`endif
    return e;
  endfunction

  // Monitor: owns out_ready, checks hold stability and every handshake.
  initial begin
    logic        hold;
    logic [35:0] prev_a;
    logic [15:0] prev_b;
    exp_t        e;
    hold = 1'b0;
    prev_a = '0;
    prev_b = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          check("hold_valid", {63'd0, out_valid_a}, 64'd1);
          check("hold_data_a", {28'd0, out_data_a}, {28'd0, prev_a});
          check("hold_data_b", {48'd0, out_data_b}, {48'd0, prev_b});
        end
        if (out_valid_a) check("in_ready_in_out", {63'd0, in_ready_a}, 64'd0);
        out_ready = ($urandom_range(99) < rdy_pct);
        if (out_valid_a && out_ready) begin
          if (q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL spurious_out: got data 0x%0h with nothing expected", out_data_a);
          end else begin
            e = q.pop_front();
            check("out_data_a", {28'd0, out_data_a}, {28'd0, e.a});
            check("out_sat_a", {63'd0, out_sat_a}, 64'd0);
            check("out_valid_b", {63'd0, out_valid_b}, 64'd1);
            check("out_data_b", {48'd0, out_data_b}, {48'd0, e.b});
            check("out_sat_b", {63'd0, out_sat_b}, {63'd0, e.sb});
          end
        end
        hold   = out_valid_a && !out_ready;
        prev_a = out_data_a;
        prev_b = out_data_b;
      end
    end
  end

  task automatic wr_coef(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    coef_we = 1'b1; coef_addr = a; coef_wdata = d;
    if (a < TAPS) cm[a] = sx16(d);
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  // Issue one sample; optionally write a coefficient on MAC edge wpos+1.
  task automatic send(input logic [15:0] d, input int wpos,
                      input logic [3:0] waddr, input logic [15:0] wdata);
    int     guard;
    longint sum;
    @(negedge clk);
    in_valid = 1'b1; in_data = d;
    guard = 0;
    while (!in_ready_a && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) begin
      check("accept_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      return;
    end
    for (int i = TAPS - 1; i > 0; i--) xm[i] = xm[i-1];
    xm[0] = sx16(d);
    sum = 0;
    for (int m = 0; m < TAPS; m++) begin
      @(negedge clk);
      if (m == 0) begin
        in_valid = 1'($urandom_range(1));
        in_data  = 16'($urandom);
      end
      check("in_ready_busy", {63'd0, in_ready_a}, 64'd0);
      check("latency_low", {63'd0, out_valid_a}, 64'd0);
      coef_we = 1'b0;
      sum += xm[m] * cm[m];
      if (m == wpos) begin
        coef_we = 1'b1; coef_addr = waddr; coef_wdata = wdata;
        if (waddr < TAPS) cm[waddr] = sx16(wdata);
      end
      if (m == TAPS - 1) q.push_back(mk_exp(sum));
    end
    @(negedge clk);
    coef_we = 1'b0;
    in_valid = 1'b0;
    check("latency_high", {63'd0, out_valid_a}, 64'd1);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((q.size() != 0 || !in_ready_a) && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (g >= 500) check("drain_timeout", 64'd0, 64'd1);
  endtask

  function automatic logic [15:0] rnd_val();
    if ($urandom_range(1) == 1) return 16'($urandom);
    return 16'($urandom_range(0, 63)) - 16'd32;
  endfunction

  initial begin
    for (int i = 0; i < TAPS; i++) begin
      xm[i] = 0;
      cm[i] = 0;
    end
    repeat (3) @(negedge clk);
    check("rst_in_ready", {63'd0, in_ready_a}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid_a}, 64'd0);
    check("rst_out_data", {28'd0, out_data_a}, 64'd0);
    check("rst_out_sat", {62'd0, out_sat_a, out_sat_b}, 64'd0);
    reset = 1'b0;

    // Impulse response with c[k] = k+1, then one more zero
    for (int k = 0; k < TAPS; k++) wr_coef(4'(k), 16'(k + 1));
    send(16'd1, -1, 4'd0, 16'd0);
    for (int i = 0; i < TAPS; i++) send(16'd0, -1, 4'd0, 16'd0);
    drain();

    // Out-of-range coefficient addresses are ignored
    for (int k = 0; k < TAPS; k++) wr_coef(4'(k), 16'd1);
    wr_coef(4'd9, 16'h1234);
    wr_coef(4'd15, 16'h7777);
    send(16'd1, -1, 4'd0, 16'd0);
    for (int i = 0; i < TAPS - 1; i++) send(16'd0, -1, 4'd0, 16'd0);
    drain();

    // Step with full-scale input and 0x4000 coefficients
    for (int k = 0; k < TAPS; k++) wr_coef(4'(k), 16'h4000);
    for (int i = 0; i < TAPS; i++) send(16'h7FFF, -1, 4'd0, 16'd0);
    drain();

    // Narrowing extremes on B
    for (int k = 1; k < TAPS; k++) wr_coef(4'(k), 16'd0);
    wr_coef(4'd0, 16'h7FFF);
    send(16'h7FFF, -1, 4'd0, 16'd0);
    wr_coef(4'd0, 16'h8000);
    send(16'h7FFF, -1, 4'd0, 16'd0);
    wr_coef(4'd0, 16'h0010);
    send(16'h0123, -1, 4'd0, 16'd0);
    drain();

    // Backpressure with in_valid held high in OUT
    rdy_pct = 0;
    send(16'h0042, -1, 4'd0, 16'd0);
    in_valid = 1'b1;
    in_data  = 16'h5555;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", {63'd0, in_ready_a}, 64'd0);
      check("bp_out_valid", {63'd0, out_valid_a}, 64'd1);
    end
    in_valid = 1'b0;
    rdy_pct  = 100;
    begin
      int g;
      g = 0;
      while (out_valid_a && g < 20) begin
        @(negedge clk);
        g++;
      end
      check("bp_release_ready", {63'd0, in_ready_a}, 64'd1);
    end
    drain();

    // Reset while MAC is at k=4
    for (int k = 0; k < TAPS; k++) wr_coef(4'(k), 16'(k + 1));
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'd7;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_out_valid", {63'd0, out_valid_a}, 64'd0);
    check("mid_rst_in_ready", {63'd0, in_ready_a}, 64'd1);
    for (int i = 0; i < TAPS; i++) begin
      xm[i] = 0;
      cm[i] = 0;
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {63'd0, in_ready_a}, 64'd1);
    check("post_rst_out_valid", {63'd0, out_valid_a}, 64'd0);
    send(16'd5, -1, 4'd0, 16'd0);
    for (int k = 0; k < TAPS; k++) wr_coef(4'(k), 16'(k + 1));
    send(16'd1, -1, 4'd0, 16'd0);
    drain();

    // Random samples, coefficients, mid-MAC writes and backpressure
    for (int k = 0; k < TAPS; k++) wr_coef(4'(k), rnd_val());
    rdy_pct = 60;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(3) == 0) wr_coef(4'($urandom_range(0, 15)), rnd_val());
      if ($urandom_range(1) == 1)
        send(rnd_val(), $urandom_range(0, TAPS - 1), 4'($urandom_range(0, 15)), rnd_val());
      else
        send(rnd_val(), -1, 4'd0, 16'd0);
    end
    rdy_pct = 100;
    drain();
    check("queue_empty", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
